// File: rtl/pixel_pkg.sv
// pixel_pkg: shared FSM state encoding, point-operation codes and pixel geometry helper
package pixel_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, DATA, DONE} state_t;
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_INVERT = 2'd2;
  localparam logic [1:0] MODE_BRIGHT = 2'd3;
  function automatic int channels();
    return 3;
  endfunction
endpackage

// File: rtl/pixel_point_op.sv
// pixel_point_op: combinational pass/threshold/invert/brightness on one {R,G,B} pixel
module pixel_point_op
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int PW = channels() * DATA_WIDTH
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] param,
  input  logic [PW-1:0]         pix_in,
  output logic [PW-1:0]         pix_out
);
  localparam int W2 = DATA_WIDTH + 2;
  logic [W2-1:0] sum, thr;
  logic [DATA_WIDTH-1:0] ch;
  logic [DATA_WIDTH:0] br;
  always_comb begin
    sum = '0;
    ch = '0;
    br = '0;
    pix_out = '0;
    for (int i = 0; i < channels(); i++) sum = sum + W2'(pix_in[i*DATA_WIDTH +: DATA_WIDTH]);
    thr = W2'(param) + W2'({param, 1'b0});
    for (int i = 0; i < channels(); i++) begin
      ch = pix_in[i*DATA_WIDTH +: DATA_WIDTH];
      br = {1'b0, ch} + {1'b0, param};
      pix_out[i*DATA_WIDTH +: DATA_WIDTH] = mode == MODE_PASS ? ch :
                                            mode == MODE_THRESH ? {DATA_WIDTH{sum > thr}} :
                                            mode == MODE_INVERT ? ~ch :
                                            br[DATA_WIDTH] ? '1 : br[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: frame/row sync generator streaming LANES point-processed pixels per beat
module pixel_stream_gen
  import pixel_pkg::*;
#(
  parameter int IMAGE_WIDTH = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 2,
  parameter int START_DELAY = 100,
  parameter int HSYNC_DELAY = 160,
  localparam int BW = LANES * channels() * DATA_WIDTH,
  localparam int RW = $clog2(IMAGE_HEIGHT),
  localparam int CW = $clog2(IMAGE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] param_val,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BW-1:0]         in_data,
  output logic                  out_valid,
  output logic [BW-1:0]         out_data,
  output logic                  vsync,
  output logic                  hsync,
  output logic [RW-1:0]         row,
  output logic [CW-1:0]         col,
  output logic                  done
);
  localparam int PW = channels() * DATA_WIDTH;
  localparam int DMAX = START_DELAY > HSYNC_DELAY ? START_DELAY : HSYNC_DELAY;
  localparam int DW = $clog2(DMAX + 1);
  state_t state, state_n;
  logic [DW-1:0] dly;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [1:0] mode_q;
  logic [DATA_WIDTH-1:0] param_q;
  logic [BW-1:0] op_data;
  logic fire, row_end, last_row, dly_end;
  assign in_ready = state == DATA;
  // vsync covers DONE so the final beat still carries it; done is registered one cycle later
  assign vsync = state != IDLE;
  assign hsync = out_valid;
  assign fire = in_valid & in_ready;
  assign row_end = col_cnt == CW'(IMAGE_WIDTH - LANES);
  assign last_row = row_cnt == RW'(IMAGE_HEIGHT - 1);
  assign dly_end = dly == DW'((state == VSYNC ? START_DELAY : HSYNC_DELAY) - 1);
  always_comb begin
    state_n = state == IDLE ? (start ? VSYNC : IDLE) :
              state == VSYNC ? (dly_end ? HSYNC : VSYNC) :
              state == HSYNC ? (dly_end ? DATA : HSYNC) :
              state == DATA ? (fire && row_end ? (last_row ? DONE : HSYNC) : DATA) :
              IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      mode_q <= MODE_PASS;
      param_q <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      row <= '0;
      col <= '0;
      done <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        param_q <= param_val;
      end
      dly <= (state_n != state || (state != VSYNC && state != HSYNC)) ? '0 : dly + 1'b1;
      if (fire) begin
        col_cnt <= row_end ? '0 : col_cnt + CW'(LANES);
        if (row_end) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        out_data <= op_data;
        row <= row_cnt;
        col <= col_cnt;
      end
      out_valid <= fire;
      done <= state == DONE;
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pixel_point_op #(.DATA_WIDTH(DATA_WIDTH)) u_op (
      .mode(mode_q),
      .param(param_q),
      .pix_in(in_data[g*PW +: PW]),
      .pix_out(op_data[g*PW +: PW])
    );
  end
endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: scoreboard bench for framing, point operations, stalls and mid-frame reset
module tb_pixel_stream_gen;
  typedef struct packed {logic [47:0] d; logic r; logic [2:0] c;} exp_t;
  typedef struct packed {logic [95:0] d; logic r; logic [2:0] c;} exp_b_t;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, out_valid, vsync, hsync, done;
  logic [1:0] mode;
  logic [7:0] param_val;
  logic [47:0] in_data, out_data;
  logic row;
  logic [2:0] col;
  logic start_b, in_valid_b, in_ready_b, out_valid_b, vsync_b, hsync_b, done_b;
  logic [1:0] mode_b;
  logic [7:0] param_b;
  logic [95:0] in_data_b, out_data_b;
  logic row_b;
  logic [2:0] col_b;
  int errors = 0, checks = 0, cyc = 0;
  int rise_cyc, first_cyc, last_cyc, row0_end, row1_cyc, done_cyc, nbeats, ndone, ndone_b;
  int exp_row, exp_col, exp_col_b, exp_row_b;
  logic vs_prev = 1'b0, done_vs;
  exp_t q[$];
  exp_b_t qb[$];
  logic [23:0] pin[16], pex[16];

  pixel_stream_gen #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .DATA_WIDTH(8), .LANES(2),
                     .START_DELAY(4), .HSYNC_DELAY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .param_val(param_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_data(out_data), .vsync(vsync), .hsync(hsync), .row(row), .col(col), .done(done));

  pixel_stream_gen #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .DATA_WIDTH(8), .LANES(4),
                     .START_DELAY(4), .HSYNC_DELAY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .param_val(param_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .out_valid(out_valid_b),
    .out_data(out_data_b), .vsync(vsync_b), .hsync(hsync_b), .row(row_b), .col(col_b), .done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vsync && !vs_prev) begin
      rise_cyc = cyc;
      first_cyc = 0;
      nbeats = 0;
      ndone = 0;
    end
    vs_prev = vsync;
    if (out_valid) begin
      if (first_cyc == 0) first_cyc = cyc;
      last_cyc = cyc;
      nbeats++;
      if (row == 1'b0 && col == 3'd6) row0_end = cyc;
      if (row == 1'b1 && col == 3'd0) row1_cyc = cyc;
      if (q.size() == 0) chk("unexpected_beat", out_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("row", row, e.r);
        chk("col", col, e.c);
        chk("hsync", hsync, 1'b1);
        chk("vsync_on_beat", vsync, 1'b1);
      end
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
      done_vs = vsync;
    end
  end

  always @(negedge clk) begin
    exp_b_t e;
    if (out_valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_beat", out_valid_b, 1'b0);
      else begin
        e = qb.pop_front();
        chk("b_out_data", out_data_b, e.d);
        chk("b_row", row_b, e.r);
        chk("b_col", col_b, e.c);
      end
    end
    if (done_b) ndone_b++;
  end

  task automatic rst_chk();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_vsync", vsync, 1'b0);
    chk("rst_hsync", hsync, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_row", row, 1'b0);
    chk("rst_col", col, 3'd0);
    chk("rst_out_data", out_data, 48'd0);
  endtask

  task automatic fill(input logic [95:0] ins, input logic [95:0] exs);
    for (int k = 0; k < 16; k++) begin
      pin[k] = ins[(k % 4) * 24 +: 24];
      pex[k] = exs[(k % 4) * 24 +: 24];
    end
  endtask

  task automatic fill_count();
    for (int k = 0; k < 16; k++) begin
      pin[k] = {8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)};
      pex[k] = pin[k];
    end
  endtask

  task automatic send(input logic [47:0] d, input logic [47:0] e);
    int n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    if (in_ready) begin
      q.push_back('{d: e, r: exp_row[0], c: exp_col[2:0]});
      exp_col = (exp_col + 2) % 8;
      if (exp_col == 0) exp_row = (exp_row + 1) % 2;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] p, input bit stall, input bit mid, input bit abort);
    int c0, n;
    exp_row = 0;
    exp_col = 0;
    chk("vsync_idle", vsync, 1'b0);
    mode = m;
    param_val = p;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    param_val = ~p;
    chk("vsync_after_start", vsync, 1'b1);
    for (int b = 0; b < 8; b++) begin
      if (abort && b == 6) begin
        in_data = {pin[13], pin[12]};
        in_valid = 1'b1;
        #2 reset = 1'b1;
        #1 rst_chk();
        q.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_valid", out_valid, 1'b0);
        chk("idle_after_reset_vsync", vsync, 1'b0);
        return;
      end
      if (mid && b == 2) start = 1'b1;
      send({pin[2*b+1], pin[2*b]}, {pex[2*b+1], pex[2*b]});
      start = 1'b0;
      if (stall && b == 1) repeat (2) @(negedge clk);
    end
    n = 0;
    while (ndone == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("vsync_rise_cycle", 96'(rise_cyc - c0), 96'd1);
    chk("first_beat_latency", 96'(first_cyc - rise_cyc), 96'd8);
    chk("row_gap", 96'(row1_cyc - row0_end), 96'd4);
    chk("beat_count", 96'(nbeats), 96'd8);
    chk("done_count", 96'(ndone), 96'd1);
    chk("done_after_last", 96'(done_cyc - last_cyc), 96'd1);
    chk("vsync_at_done", done_vs, 1'b0);
    chk("queue_drained", 96'(q.size()), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    param_val = 8'd0;
    in_valid = 1'b0;
    in_data = '0;
    start_b = 1'b0;
    mode_b = 2'd0;
    param_b = 8'd0;
    in_valid_b = 1'b0;
    in_data_b = '0;
    repeat (3) @(negedge clk);
    rst_chk();
    reset = 1'b0;
    @(negedge clk);
    fill_count();
    run_frame(2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    fill({24'h595a5a, 24'hffffff, 24'h5b5a5a, 24'h5a5a5a},
         {24'h000000, 24'hffffff, 24'hffffff, 24'h000000});
    run_frame(2'd1, 8'd90, 1'b0, 1'b0, 1'b0);
    fill({24'h000000, 24'hffffff, 24'h0a141e, 24'h0080ff},
         {24'hffffff, 24'h000000, 24'hf5ebe1, 24'hff7f00});
    run_frame(2'd2, 8'd0, 1'b1, 1'b0, 1'b0);
    fill({24'h000000, 24'h9a9c00, 24'h9b00ff, 24'h0ac89b},
         {24'h646464, 24'hfeff64, 24'hff64ff, 24'h6effff});
    run_frame(2'd3, 8'd100, 1'b0, 1'b0, 1'b0);
    fill_count();
    run_frame(2'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    run_frame(2'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    exp_col_b = 0;
    exp_row_b = 0;
    ndone_b = 0;
    mode_b = 2'd3;
    param_b = 8'd100;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_data_b = {24'h000000, 24'h9a9c00, 24'h9b00ff, 24'h0ac89b};
      in_valid_b = 1'b1;
      n = 0;
      while (!in_ready_b && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b_in_ready_wait", in_ready_b, 1'b1);
      qb.push_back('{d: {24'h646464, 24'hfeff64, 24'hff64ff, 24'h6effff}, r: exp_row_b[0], c: exp_col_b[2:0]});
      exp_col_b = (exp_col_b + 4) % 8;
      if (exp_col_b == 0) exp_row_b = (exp_row_b + 1) % 2;
      @(negedge clk);
      in_valid_b = 1'b0;
    end
    n = 0;
    while (ndone_b == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("b_done_count", 96'(ndone_b), 96'd1);
    chk("b_queue_drained", 96'(qb.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
- Parametrised successor to the image read/sync generator.
- Accepts an RGB pixel stream from a frame source over a valid/ready handshake.
- Emits LANES pixels per beat, together with vertical/horizontal sync framing and a per-frame done pulse.
- Applies a run-time selectable point operation (pass, threshold, invert, brightness) before the pixels reach the writer stage.

Parameters:
- IMAGE_WIDTH, 768, pixels per row; must be a multiple of LANES.
- IMAGE_HEIGHT, 512, rows per frame.
- DATA_WIDTH, 8, bits per colour channel.
- LANES, 2, pixels per beat (2 reproduces the even/odd pair).
- START_DELAY, 100, cycles in vertical sync before the first row.
- HSYNC_DELAY, 160, blanking cycles before each row.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame request.
- mode  in  2  operation select: 0 pass, 1 threshold, 2 invert, 3 brightness.
- param_val  in  DATA_WIDTH  threshold level (mode 1) or brightness offset (mode 3).
- in_valid  in  1  source pixel beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  LANES*3*DATA_WIDTH  per lane {R,G,B}; lane 0 in the LSBs and is the leftmost pixel.
- out_valid  out  1  processed beat valid.
- out_data  out  LANES*3*DATA_WIDTH  processed pixels, same packing as in_data.
- vsync  out  1  frame active.
- hsync  out  1  row data active (qualifies out_valid).
- row  out  $clog2(IMAGE_HEIGHT)  row of the current out beat.
- col  out  $clog2(IMAGE_WIDTH)  pixel index of lane 0 of the current out beat.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset takes effect mid-frame immediately; after release, no output until a new start.
- FSM states: IDLE, VSYNC, HSYNC, DATA, DONE.
  - IDLE: on start=1, latch mode and param_val, go to VSYNC. start is ignored in all other states.
  - VSYNC: stays exactly START_DELAY cycles, then goes to HSYNC.
  - HSYNC: stays exactly HSYNC_DELAY cycles, then goes to DATA.
  - DATA: in_ready=1. Each accepted beat (in_valid & in_ready) advances the beat counter. After IMAGE_WIDTH/LANES beats:
    - if rows remain, go to HSYNC and increment row;
    - after the last beat of row IMAGE_HEIGHT-1, go to DONE.
  - DONE: lasts 1 cycle, then returns to IDLE.
- in_ready: 0 in every state except DATA. A stalled source (in_valid=0 in DATA) holds the counters and emits no beat. There is no output backpressure.
- Latency: exactly 1 cycle from the input handshake to out_valid=1, with out_data, row and col registered together. hsync equals out_valid.
- vsync:
  - 1 from the cycle after start is accepted until the cycle before done;
  - 0 in the done cycle;
  - the final out beat therefore appears with vsync=1, and done rises the cycle after it.
- col increments by LANES per beat and wraps to 0 at each row end. row wraps to 0 at frame end.
- Per-lane operations, applied independently to each lane:
  - Mode 0: output equals input.
  - Mode 1: sum = R+G+B at DATA_WIDTH+2 bits. If sum > 3*param_val (same width), all channels = all-ones; otherwise all channels = 0. Equality gives 0.
  - Mode 2: each channel = all-ones minus channel.
  - Mode 3: each channel = channel + param_val, saturating at all-ones; no wrap.
- mode and param_val changes during a frame have no effect until the next start.

Decomposition:
- Shared package (pixel_pkg):
  - state encoding constants;
  - mode codes MODE_PASS=0, MODE_THRESH=1, MODE_INVERT=2, MODE_BRIGHT=3;
  - helper function for the channel count (3).
- Sub-module pixel_point_op: combinational, one pixel in, one pixel out, with mode and param inputs. It is instantiated LANES times via generate, and the registering is done in the parent.

Test Plan:
All scenarios use IMAGE_WIDTH=8, IMAGE_HEIGHT=2, LANES=2, START_DELAY=4, HSYNC_DELAY=3, DATA_WIDTH=8 unless stated otherwise.
1. Mode 0, in_valid held high, counting pattern -> framing and timing:
   - vsync rises 1 cycle after start;
   - first out_valid at cycle 1+4+3+1;
   - 4 beats per row with col values 0,2,4,6;
   - 3-cycle hsync gap between rows;
   - 8 beats total;
   - done pulses 1 cycle after the last beat.
2. Mode 1, param_val=90:
   - pixel {90,90,90} -> {0,0,0};
   - pixel {91,90,90} -> {255,255,255};
   - pixel {255,255,255} -> all 255.
3. Mode 2 with {0,128,255} -> {255,127,0}. Mode 3 with param_val=100 and {10,200,155} -> {110,255,255}.
4. in_valid toggled 1,0,0,1 mid-row -> no out_valid for the stalled beats; col continuity is preserved; total beat count is unchanged.
5. reset asserted during row 1 beat 2 -> all outputs 0 immediately. A new start after release gives a full frame starting at row 0, col 0. A start pulsed during DATA is ignored.
6. LANES=4, IMAGE_WIDTH=8 -> 2 beats per row, col values 0 and 4; lanes are processed independently.
